// File: rtl/ast_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ast_ctrl
// Brief    : Sensor assert (AST) line sequencer: timed pulse, optional echo
//            wait with timeout, status byte with sticky flags and pulse count.
// Revision : 1.0
// ============================================================================
module ast_ctrl #(
    parameter int TICK_DIV = 100,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [7:0] cmd_ast,
    input  logic [7:0] cfg_pol,
    input  logic [7:0] cfg_width,
    input  logic       sensor_rdy,
    output logic       ast_out,
    output logic [7:0] stu_sensor
);

    localparam logic [1:0]  c_st_idle     = 2'd0;
    localparam logic [1:0]  c_st_pulse    = 2'd1;
    localparam logic [1:0]  c_st_wait_ack = 2'd2;

    localparam logic [7:0]  c_cmd_fire     = 8'h01;
    localparam logic [7:0]  c_cmd_fire_ack = 8'h02;
    localparam logic [7:0]  c_cmd_clr      = 8'h80;
    localparam logic [7:0]  c_cmd_abort    = 8'hFF;

    localparam logic [15:0] c_div_last = 16'(TICK_DIV - 1);
    localparam logic [15:0] c_timeout  = 16'(TIMEOUT);

    logic [1:0]  r_state;
    logic        r_pol_l;
    logic [7:0]  r_w_l;
    logic        r_is_ack;
    logic [15:0] r_presc;
    logic [15:0] r_tick_cnt;
    logic        r_done;
    logic        r_timeout;
    logic        r_overrun;
    logic [3:0]  r_count;
    logic        r_ast_out;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rdy_d;
    logic        r_rdy_edge;

    logic        w_fire_any;
    logic        w_clr;
    logic        w_abort;
    logic        w_busy;
    logic        w_tick;
    logic [15:0] w_tick_nxt;
    logic        w_width_hit;
    logic        w_timeout_hit;
    logic [3:0]  w_count_base;
    logic        w_unused;

    assign w_fire_any    = (cmd_ast == c_cmd_fire) || (cmd_ast == c_cmd_fire_ack);
    assign w_clr         = (cmd_ast == c_cmd_clr);
    assign w_abort       = (cmd_ast == c_cmd_abort);
    assign w_busy        = (r_state != c_st_idle);
    assign w_tick        = (r_presc == c_div_last);
    assign w_tick_nxt    = r_tick_cnt + 16'd1;
    assign w_width_hit   = w_tick && (w_tick_nxt == {8'd0, r_w_l});
    assign w_timeout_hit = w_tick && (w_tick_nxt == c_timeout);
    // A CLR landing on a completion cycle restarts the count from zero
    assign w_count_base  = w_clr ? 4'd0 : r_count;
    assign w_unused      = &{1'b0, cfg_pol[7:1]};

    assign ast_out    = r_ast_out;
    assign stu_sensor = {r_count, r_overrun, r_timeout, r_done, w_busy};

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_rdy_d    <= 1'b0;
            r_rdy_edge <= 1'b0;
        end else begin
            r_sync1    <= sensor_rdy;
            r_sync2    <= r_sync1;
            r_rdy_d    <= r_sync2;
            r_rdy_edge <= r_sync2 & ~r_rdy_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_pol_l    <= 1'b0;
            r_w_l      <= 8'd1;
            r_is_ack   <= 1'b0;
            r_presc    <= 16'd0;
            r_tick_cnt <= 16'd0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
            r_count    <= 4'd0;
            r_ast_out  <= 1'b0;
        end else begin
            if (w_clr) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_overrun <= 1'b0;
                r_count   <= 4'd0;
            end
            if (w_tick) begin
                r_presc    <= 16'd0;
                r_tick_cnt <= w_tick_nxt;
            end else begin
                r_presc <= r_presc + 16'd1;
            end

            case (r_state)
                c_st_idle: begin
                    r_presc    <= 16'd0;
                    r_tick_cnt <= 16'd0;
                    r_pol_l    <= cfg_pol[0];
                    r_ast_out  <= cfg_pol[0];
                    if (w_fire_any) begin
                        r_state   <= c_st_pulse;
                        r_ast_out <= ~cfg_pol[0];
                        r_w_l     <= (cfg_width == 8'd0) ? 8'd1 : cfg_width;
                        r_is_ack  <= (cmd_ast == c_cmd_fire_ack);
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                c_st_pulse: begin
                    r_ast_out <= ~r_pol_l;
                    if (w_fire_any) r_overrun <= 1'b1;
                    if (w_abort) begin
                        r_state   <= c_st_idle;
                        r_ast_out <= r_pol_l;
                    end else if (w_width_hit) begin
                        r_ast_out  <= r_pol_l;
                        r_presc    <= 16'd0;
                        r_tick_cnt <= 16'd0;
                        if (r_is_ack) begin
                            r_state <= c_st_wait_ack;
                        end else begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                            r_count <= w_count_base + 4'd1;
                        end
                    end
                end
                c_st_wait_ack: begin
                    r_ast_out <= r_pol_l;
                    if (w_fire_any) r_overrun <= 1'b1;
                    if (w_abort) begin
                        r_state <= c_st_idle;
                    end else if (r_rdy_edge) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                        r_count <= w_count_base + 4'd1;
                    end else if (w_timeout_hit) begin
                        r_state   <= c_st_idle;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_ast_out <= r_pol_l;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ast_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ast_ctrl
// Brief    : Self-checking bench for ast_ctrl (TICK_DIV=4, TIMEOUT=8).
// Revision : 1.0
// ============================================================================
module tb_ast_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 8;

    localparam logic [7:0] c_fire     = 8'h01;
    localparam logic [7:0] c_fire_ack = 8'h02;
    localparam logic [7:0] c_clr      = 8'h80;
    localparam logic [7:0] c_abort    = 8'hFF;

    typedef struct {
        int         len;
        logic [7:0] stu;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic [7:0] cmd_ast;
    logic [7:0] cfg_pol;
    logic [7:0] cfg_width;
    logic       sensor_rdy;
    logic       ast_out;
    logic [7:0] stu_sensor;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk_sys = ~clk_sys;

    ast_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .cmd_ast    (cmd_ast),
        .cfg_pol    (cfg_pol),
        .cfg_width  (cfg_width),
        .sensor_rdy (sensor_rdy),
        .ast_out    (ast_out),
        .stu_sensor (stu_sensor)
    );

    // Caller sits on a negedge; returns on the negedge after the sampling edge
    task automatic strobe(input logic [7:0] cmd);
        cmd_ast = cmd;
        @(negedge clk_sys);
        cmd_ast = 8'h00;
    endtask

    task automatic measure(input logic idle, output int len);
        len = 0;
        while (ast_out !== idle && len < 1000) begin
            len++;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_ast = 8'h00; cfg_pol = 8'h00; cfg_width = 8'h00; sensor_rdy = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_checks++;
        if (ast_out !== 1'b0) begin n_errors++; $display("FAIL reset_ast: got %b exp 0", ast_out); end
        n_checks++;
        if (stu_sensor !== 8'h00) begin n_errors++; $display("FAIL reset_stu: got %h exp 00", stu_sensor); end
        rst = 1'b0;
        @(negedge clk_sys);
        n_checks++;
        if (stu_sensor !== 8'h00) begin n_errors++; $display("FAIL post_reset_stu: got %h exp 00", stu_sensor); end
    endtask

    task automatic test_fire();
        int len; exp_t e;
        cfg_pol = 8'h00; cfg_width = 8'd3;
        sb.push_back('{12, 8'h12});
        strobe(c_fire);
        n_checks++;
        if (stu_sensor !== 8'h01) begin n_errors++; $display("FAIL fire_busy_stu: got %h exp 01", stu_sensor); end
        n_checks++;
        if (ast_out !== 1'b1) begin n_errors++; $display("FAIL fire_start: got %b exp 1", ast_out); end
        measure(1'b0, len);
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL fire_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL fire_stu: got %h exp %h", stu_sensor, e.stu); end
    endtask

    task automatic test_polarity();
        int len; exp_t e;
        cfg_pol = 8'h01;
        @(negedge clk_sys);
        n_checks++;
        if (ast_out !== 1'b1) begin n_errors++; $display("FAIL pol_idle: got %b exp 1", ast_out); end
        strobe(c_clr);
        cfg_width = 8'd0;
        sb.push_back('{4, 8'h12});
        strobe(c_fire);
        n_checks++;
        if (ast_out !== 1'b0) begin n_errors++; $display("FAIL pol_active: got %b exp 0", ast_out); end
        measure(1'b1, len);
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL pol_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL pol_stu: got %h exp %h", stu_sensor, e.stu); end
        cfg_pol = 8'h00;
        @(negedge clk_sys);
        n_checks++;
        if (ast_out !== 1'b0) begin n_errors++; $display("FAIL pol_restore: got %b exp 0", ast_out); end
    endtask

    task automatic test_fire_ack();
        int len; exp_t e;
        strobe(c_clr);
        cfg_width = 8'd2;
        sb.push_back('{8, 8'h12});
        strobe(c_fire_ack);
        measure(1'b0, len);
        n_checks++;
        if (stu_sensor !== 8'h01) begin n_errors++; $display("FAIL ack_waiting: got %h exp 01", stu_sensor); end
        repeat (9) @(negedge clk_sys);
        sensor_rdy = 1'b1;
        repeat (3) @(negedge clk_sys);
        n_checks++;
        if (stu_sensor !== 8'h01) begin n_errors++; $display("FAIL ack_early: got %h exp 01", stu_sensor); end
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL ack_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL ack_done: got %h exp %h", stu_sensor, e.stu); end
        sensor_rdy = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_timeout();
        int len; exp_t e;
        strobe(c_clr);
        cfg_width = 8'd1;
        sb.push_back('{4, 8'h04});
        strobe(c_fire_ack);
        measure(1'b0, len);
        n_checks++;
        if (stu_sensor !== 8'h01) begin n_errors++; $display("FAIL to_entry: got %h exp 01", stu_sensor); end
        repeat (31) @(negedge clk_sys);
        n_checks++;
        if (stu_sensor !== 8'h01) begin n_errors++; $display("FAIL to_early: got %h exp 01", stu_sensor); end
        @(negedge clk_sys);
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL to_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL to_stu: got %h exp %h", stu_sensor, e.stu); end
    endtask

    task automatic test_overrun();
        int len; exp_t e;
        strobe(c_clr);
        cfg_width = 8'd3;
        sb.push_back('{12, 8'h1A});
        strobe(c_fire);
        len = 0;
        while (ast_out !== 1'b0 && len < 1000) begin
            len++;
            cmd_ast = (len == 5) ? c_fire : 8'h00;
            @(negedge clk_sys);
        end
        cmd_ast = 8'h00;
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL ovr_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL ovr_stu: got %h exp %h", stu_sensor, e.stu); end
        // CLR lands on the completion edge
        sb.push_back('{12, 8'h12});
        strobe(c_fire);
        len = 0;
        while (ast_out !== 1'b0 && len < 1000) begin
            len++;
            cmd_ast = (len == 12) ? c_clr : 8'h00;
            @(negedge clk_sys);
        end
        cmd_ast = 8'h00;
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL clr_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL clr_same_cycle: got %h exp %h", stu_sensor, e.stu); end
    endtask

    task automatic test_abort_reset();
        exp_t e;
        cfg_width = 8'd3;
        strobe(c_fire);
        n_checks++;
        if (stu_sensor !== 8'h11) begin n_errors++; $display("FAIL abort_busy: got %h exp 11", stu_sensor); end
        repeat (3) @(negedge clk_sys);
        sb.push_back('{0, 8'h10});
        strobe(c_abort);
        e = sb.pop_front();
        n_checks++;
        if (ast_out !== 1'b0) begin n_errors++; $display("FAIL abort_ast: got %b exp 0", ast_out); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL abort_stu: got %h exp %h", stu_sensor, e.stu); end
        strobe(c_fire);
        repeat (2) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        n_checks++;
        if (ast_out !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ast: got %b exp 0", ast_out); end
        n_checks++;
        if (stu_sensor !== 8'h00) begin n_errors++; $display("FAIL rst_mid_stu: got %h exp 00", stu_sensor); end
        rst = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_back_to_back();
        int len; exp_t e;
        strobe(c_clr);
        cfg_width = 8'd0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{4, {4'((i + 1) % 16), 4'h2}});
            strobe(c_fire);
            measure(1'b0, len);
            e = sb.pop_front();
            n_checks++;
            if (len !== e.len) begin n_errors++; $display("FAIL b2b_len[%0d]: got %0d exp %0d", i, len, e.len); end
            n_checks++;
            if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL b2b_stu[%0d]: got %h exp %h", i, stu_sensor, e.stu); end
        end
    endtask

    task automatic test_width_change();
        int len; exp_t e;
        strobe(c_clr);
        cfg_width = 8'd2;
        sb.push_back('{8, 8'h12});
        strobe(c_fire);
        len = 0;
        while (ast_out !== 1'b0 && len < 1000) begin
            len++;
            if (len == 3) cfg_width = 8'd7;
            @(negedge clk_sys);
        end
        e = sb.pop_front();
        n_checks++;
        if (len !== e.len) begin n_errors++; $display("FAIL wchg_len: got %0d exp %0d", len, e.len); end
        n_checks++;
        if (stu_sensor !== e.stu) begin n_errors++; $display("FAIL wchg_stu: got %h exp %h", stu_sensor, e.stu); end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_polarity();
        test_fire_ack();
        test_timeout();
        test_overrun();
        test_abort_reset();
        test_back_to_back();
        test_width_change();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
